wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: i_clk  in  1  rising-edge clock; i_rst  in  1  async active-high reset.
REQ-002 i_req0_valid  in  1  ALU writeback request; i_req0_addr  in  5  destination reg; i_req0_data  in  32  write data; o_req0_ready  out  1  grant/accept.
REQ-003 i_req1_valid  in  1  load-unit writeback request; i_req1_addr  in  5; i_req1_data  in  32; o_req1_ready  out  1.
REQ-004 o_we3  out  1  reg-file write enable; o_addr3  out  5  reg-file write address; o_wd3  out  32  reg-file write data.
REQ-005 i_issue_valid  in  1  instruction issued with a register destination; i_issue_rd  in  5  its destination.
REQ-006 i_rs1, i_rs2  in  5  source regs of the instruction in decode; o_stall_rs1, o_stall_rs2  out  1  source pending.
REQ-007 o_busy  out  32  scoreboard of registers with an outstanding write.

Function
REQ-008 A requester SHALL transfer on a rising edge where valid and ready are both high; ready SHALL be combinational from valids and the priority state, and at most one ready SHALL be high per cycle.
REQ-009 Ready SHALL never be asserted without the matching valid; a lone valid requester SHALL be granted in the same cycle (no bubble).
REQ-010 Priority state SHALL be a 2-state FSM, PRI0 and PRI1; on both valids, PRI0 grants req0 and PRI1 grants req1.
REQ-011 After a transfer from req0 the FSM SHALL go to PRI1, and after a transfer from req1 to PRI0; with no transfer the state SHALL hold.
REQ-012 Write port outputs SHALL be registered: a transfer at edge N drives o_we3=1, o_addr3, o_wd3 from the winner during cycle N+1 (latency 1); with no transfer o_we3=0 next cycle.
REQ-013 A transfer with address 0 SHALL complete the handshake but leave o_we3=0 in the following cycle.
REQ-014 Back-to-back transfers SHALL sustain one write per cycle.
REQ-015 Scoreboard: an edge with i_issue_valid=1 and i_issue_rd!=0 SHALL set o_busy[i_issue_rd]; i_issue_rd=0 SHALL be ignored.
REQ-016 An edge with a transfer to address A!=0 SHALL clear o_busy[A].
REQ-017 If issue sets and a transfer clears the same register on the same edge, set SHALL win (bit stays 1).
REQ-018 Issuing to an already-busy register SHALL leave it busy; the scoreboard is one bit per register, not a count.
REQ-019 o_stall_rsX SHALL be combinational: o_busy[i_rsX] and i_rsX!=0; bit 0 of o_busy SHALL always read 0.
REQ-020 A transfer and a stall query for the same register in the same cycle SHALL still report stall in that cycle (clear visible next cycle).

Reset
REQ-021 While i_rst=1: o_we3=0, o_addr3=0, o_wd3=0, o_busy=0, FSM=PRI0, both ready=0, independent of the clock.
REQ-022 Reset asserted mid-operation SHALL discard any registered write (o_we3=0 at once) and all pending scoreboard bits.
REQ-023 After deassertion, first arbitration SHALL start from PRI0.

Configuration
REQ-024 Macro WB_ARB_FIXED_PRIO_EN defined: FSM removed and req1 (load) always wins on both valids; undefined: round-robin per REQ-010/011.
REQ-025 All other behaviour SHALL be identical in both builds.

Verification
REQ-026 Reset release, req0 valid addr 5 data 0xDEADBEEF -> ready0=1 same cycle; next cycle o_we3=1, o_addr3=5, o_wd3=0xDEADBEEF.
REQ-027 Both valid for 4 cycles (round-robin build) -> grants 0,1,0,1; writes appear one cycle later in same order; fixed-prio build -> 1,1,1,1.
REQ-028 Issue rd=7, then i_rs1=7 -> o_stall_rs1=1; req1 writes 7 -> stall drops the cycle after the transfer edge.
REQ-029 Issue rd=9 and transfer to 9 on the same edge -> o_busy[9]=1 afterwards; req0 writes addr 0 -> ready0=1, o_we3 stays 0.
REQ-030 Assert i_rst between a transfer edge and the following write cycle -> o_we3=0 immediately, o_busy=0, next grant with both valid goes to req0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Arbiter for two writeback requesters onto one reg-file write port, with a busy scoreboard.
// Latency: same-cycle grant; the write port is registered, so a write appears one cycle after its transfer; stall is combinational.
// Backpressure: the losing requester's ready stays low until it wins. Round-robin, or req1 always wins with WB_ARB_FIXED_PRIO_EN.
module wb_port_arbiter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0_valid,
    input  logic [4:0]  i_req0_addr,
    input  logic [31:0] i_req0_data,
    output logic        o_req0_ready,
    input  logic        i_req1_valid,
    input  logic [4:0]  i_req1_addr,
    input  logic [31:0] i_req1_data,
    output logic        o_req1_ready,
    output logic        o_we3,
    output logic [4:0]  o_addr3,
    output logic [31:0] o_wd3,
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    output logic        o_stall_rs1,
    output logic        o_stall_rs2,
    output logic [31:0] o_busy
);

    logic        grant0;
    logic        grant1;
    logic        xfer;
    logic [4:0]  xfer_addr;
    logic [31:0] xfer_data;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] busy_q;

`ifdef WB_ARB_FIXED_PRIO_EN
    // The load unit always wins a conflict; no priority state is kept.
    always_comb begin
        grant1 = i_req1_valid;
        grant0 = i_req0_valid & ~i_req1_valid;
    end
`else
    typedef enum logic {PRI0, PRI1} pri_t;
    pri_t pri_q;

    always_comb begin
        grant0 = i_req0_valid & (~i_req1_valid | (pri_q == PRI0));
        grant1 = i_req1_valid & (~i_req0_valid | (pri_q == PRI1));
    end

    // Priority moves to the other requester after each transfer and holds otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pri_q <= PRI0;
        end else if (o_req0_ready) begin
            pri_q <= PRI1;
        end else if (o_req1_ready) begin
            pri_q <= PRI0;
        end
    end
`endif

    // Ready is forced low during reset so no handshake can be seen while state is held.
    assign o_req0_ready = grant0 & ~i_rst;
    assign o_req1_ready = grant1 & ~i_rst;

    always_comb begin
        xfer      = o_req0_ready | o_req1_ready;
        xfer_addr = o_req1_ready ? i_req1_addr : i_req0_addr;
        xfer_data = o_req1_ready ? i_req1_data : i_req0_data;
    end

    // A transfer to r0 completes the handshake but never writes the reg file.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_we3   <= 1'b0;
            o_addr3 <= 5'd0;
            o_wd3   <= 32'd0;
        end else begin
            o_we3 <= xfer & (xfer_addr != 5'd0);
            if (xfer) begin
                o_addr3 <= xfer_addr;
                o_wd3   <= xfer_data;
            end
        end
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (i_issue_valid && (i_issue_rd != 5'd0)) begin
            set_mask = 32'd1 << i_issue_rd;
        end
        if (xfer && (xfer_addr != 5'd0)) begin
            clr_mask = 32'd1 << xfer_addr;
        end
    end

    // Set is applied after clear so a same-edge issue keeps the register pending.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
        end
    end

    assign o_busy      = busy_q;
    assign o_stall_rs1 = busy_q[i_rs1] & (i_rs1 != 5'd0);
    assign o_stall_rs2 = busy_q[i_rs2] & (i_rs2 != 5'd0);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table for handshakes, hand sequences for scoreboard and reset.
module tb_wb_port_arbiter;

`ifdef WB_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req0_valid, i_req1_valid, i_issue_valid;
    logic [4:0]  i_req0_addr, i_req1_addr, i_issue_rd, i_rs1, i_rs2;
    logic [31:0] i_req0_data, i_req1_data;
    logic        o_req0_ready, o_req1_ready, o_we3, o_stall_rs1, o_stall_rs2;
    logic [4:0]  o_addr3;
    logic [31:0] o_wd3, o_busy;

    wb_port_arbiter dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0_valid(i_req0_valid), .i_req0_addr(i_req0_addr), .i_req0_data(i_req0_data), .o_req0_ready(o_req0_ready),
        .i_req1_valid(i_req1_valid), .i_req1_addr(i_req1_addr), .i_req1_data(i_req1_data), .o_req1_ready(o_req1_ready),
        .o_we3(o_we3), .o_addr3(o_addr3), .o_wd3(o_wd3),
        .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .o_stall_rs1(o_stall_rs1), .o_stall_rs2(o_stall_rs2),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        v0; logic [4:0] a0; logic [31:0] d0;
        logic        v1; logic [4:0] a1; logic [31:0] d1;
        logic        iv; logic [4:0] ird;
        logic [4:0]  rs1; logic [4:0] rs2;
        logic        e_r0; logic e_r1; logic e_s1; logic e_s2;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t tbl[$];
    wr_t  sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mkv(logic v0, logic [4:0] a0, logic [31:0] d0,
                                 logic v1, logic [4:0] a1, logic [31:0] d1,
                                 logic iv, logic [4:0] ird, logic [4:0] rs1, logic [4:0] rs2,
                                 logic e_r0, logic e_r1, logic e_s1, logic e_s2);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_s1 = e_s1; v.e_s2 = e_s2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge: drive, check at the falling edge, queue the write expected next cycle.
    task automatic step(input vec_t v);
        wr_t e;
        wr_t w;
        i_req0_valid = v.v0; i_req0_addr = v.a0; i_req0_data = v.d0;
        i_req1_valid = v.v1; i_req1_addr = v.a1; i_req1_data = v.d1;
        i_issue_valid = v.iv; i_issue_rd = v.ird; i_rs1 = v.rs1; i_rs2 = v.rs2;
        @(negedge i_clk);
        chk("ready0", {31'd0, o_req0_ready}, {31'd0, v.e_r0});
        chk("ready1", {31'd0, o_req1_ready}, {31'd0, v.e_r1});
        chk("stall_rs1", {31'd0, o_stall_rs1}, {31'd0, v.e_s1});
        chk("stall_rs2", {31'd0, o_stall_rs2}, {31'd0, v.e_s2});
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("we3", {31'd0, o_we3}, {31'd0, e.we});
            if (e.we) begin
                chk("addr3", {27'd0, o_addr3}, {27'd0, e.addr});
                chk("wd3", o_wd3, e.data);
            end
        end
        w.we = 1'b0; w.addr = 5'd0; w.data = 32'd0;
        if (v.e_r0) begin
            w.we = (v.a0 != 5'd0); w.addr = v.a0; w.data = v.d0;
        end else if (v.e_r1) begin
            w.we = (v.a1 != 5'd0); w.addr = v.a1; w.data = v.d1;
        end
        sb.push_back(w);
        @(posedge i_clk);
        #1;
    endtask

    function automatic vec_t idle(logic [4:0] rs1, logic [4:0] rs2, logic s1, logic s2);
        return mkv(0, 0, 0, 0, 0, 0, 0, 0, rs1, rs2, 0, 0, s1, s2);
    endfunction

    initial begin
        wr_t z;
        bit  g1;
        z.we = 1'b0; z.addr = 5'd0; z.data = 32'd0;

        // Table: lone grants, then four cycles of contention starting from PRI0.
        tbl.push_back(mkv(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 3, 32'h0000_0033, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 4; i++) begin
            g1 = FIXED ? 1'b1 : i[0];
            tbl.push_back(mkv(1, 5'(10 + i), 32'hA000_0000 + i, 1, 5'(20 + i), 32'hB000_0000 + i,
                              0, 0, 0, 0, ~g1, g1, 0, 0));
        end
        tbl.push_back(mkv(0, 0, 0, 1, 30, 32'h1111_2222, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(1, 31, 32'h3333_4444, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0));

        i_rst = 1'b1;
        i_req0_valid = 1'b1; i_req0_addr = 5'd1; i_req0_data = 32'h1;
        i_req1_valid = 1'b1; i_req1_addr = 5'd2; i_req1_data = 32'h2;
        i_issue_valid = 1'b1; i_issue_rd = 5'd3; i_rs1 = 5'd0; i_rs2 = 5'd0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_we3", {31'd0, o_we3}, 32'd0);
        chk("rst_addr3", {27'd0, o_addr3}, 32'd0);
        chk("rst_wd3", o_wd3, 32'd0);
        chk("rst_busy", o_busy, 32'd0);
        chk("rst_ready0", {31'd0, o_req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, o_req1_ready}, 32'd0);
        i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_issue_valid = 1'b0;
        i_rst = 1'b0;
        sb.push_back(z);

        foreach (tbl[k]) step(tbl[k]);

        // Issue r7, stall appears, cleared by a load-unit write the cycle after the transfer.
        step(mkv(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0, 0, 0, 0));
        chk("busy_r7", o_busy, 32'h0000_0080);
        step(idle(7, 0, 1, 0));
        step(mkv(0, 0, 0, 1, 7, 32'h0000_0077, 0, 0, 7, 0, 0, 1, 1, 0));
        step(idle(7, 0, 0, 0));
        chk("busy_clr7", o_busy, 32'd0);

        // Same-edge issue and write of r9: set wins. Then a write to r0 writes nothing.
        step(mkv(1, 9, 32'h0000_0099, 0, 0, 0, 1, 9, 0, 9, 1, 0, 0, 0));
        chk("busy_set_wins", o_busy, 32'h0000_0200);
        step(mkv(1, 0, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 1));
        step(mkv(0, 0, 0, 0, 0, 0, 1, 0, 0, 9, 0, 0, 0, 1));
        chk("busy_rd0_ignored", o_busy, 32'h0000_0200);
        step(mkv(0, 0, 0, 0, 0, 0, 1, 9, 9, 9, 0, 0, 1, 1));
        chk("busy_reissue", o_busy, 32'h0000_0200);
        step(mkv(0, 0, 0, 1, 9, 32'h0000_0005, 0, 0, 9, 9, 0, 1, 1, 1));
        step(idle(9, 9, 0, 0));
        chk("busy_single_bit", o_busy, 32'd0);

        // Reset between a transfer edge and its write cycle.
        step(mkv(1, 4, 32'h0000_0044, 0, 0, 0, 1, 12, 0, 0, 1, 0, 0, 0));
        chk("pre_rst_we3", {31'd0, o_we3}, 32'd1);
        chk("pre_rst_busy", o_busy, 32'h0000_1000);
        i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        i_rst = 1'b1;
        #1;
        chk("mid_rst_we3", {31'd0, o_we3}, 32'd0);
        chk("mid_rst_busy", o_busy, 32'd0);
        chk("mid_rst_ready0", {31'd0, o_req0_ready}, 32'd0);
        sb.delete();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        sb.push_back(z);
        step(mkv(1, 13, 32'h0000_0D0D, 1, 14, 32'h0000_0E0E, 0, 0, 0, 0, ~FIXED, FIXED, 0, 0));
        step(idle(0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
